// File: rtl/mult_div.sv
// mult_div -- multicycle multiply/divide unit producing the HI/LO pair.
//
// A one-cycle start in IDLE latches the operand magnitudes and sign info,
// then RUN performs 32 radix-2 iterations (shift-add for MULT, restoring
// for DIV) on a shared 64-bit accumulator. FINISH applies sign correction
// and the registered outputs update on the following edge together with a
// one-cycle done pulse. DIV by zero skips RUN and leaves hi/lo untouched.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; aborts and clears outputs
//   start     in   request pulse, honoured only when idle
//   op[1:0]   in   op[0]: 0=MULT 1=DIV; op[1]: 1=unsigned (optional build)
//   a, b      in   32-bit operands (multiplicand/dividend, multiplier/divisor)
//   busy      out  operation in progress
//   done      out  one-cycle pulse, hi/lo valid
//   div_zero  out  one-cycle pulse with done on DIV by zero
//   hi, lo    out  MULT: product words; DIV: remainder / quotient
//
// Build option: define MULT_DIV_UNSIGNED_EN to enable MULTU/DIVU via op[1].
// Without it op[1] is ignored and every operation is signed.

module mult_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        dzo_q, dzo_d;
  logic        dz_flag_q, dz_flag_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath state: not reset, always loaded before use.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic               uns;
  logic               sa;
  logic               sb;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // One shift-add step: low half holds the remaining multiplier bits,
  // high half accumulates; the carry is shifted back into the high half.
  function automatic logic [63:0] mul_step(input logic [63:0] acc,
                                           input logic [31:0] mc);
    logic [32:0] sum;
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mc} : 33'd0);
    return {sum, acc[31:1]};
  endfunction

  // One restoring-division step: high half is the partial remainder,
  // low half shifts dividend bits out and quotient bits in.
  function automatic logic [63:0] div_step(input logic [63:0] acc,
                                           input logic [31:0] dv);
    logic [32:0] sh;
    logic [33:0] diff;
    sh   = {acc[63:32], acc[31]};
    diff = {1'b0, sh} - {2'b0, dv};
    if (!diff[33]) begin
      return {diff[31:0], acc[30:0], 1'b1};
    end
    return {sh[31:0], acc[30:0], 1'b0};
  endfunction

`ifdef MULT_DIV_UNSIGNED_EN
  assign uns = op[1];
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign uns        = 1'b0;
`endif

  assign a_s = a;
  assign b_s = b;
  assign sa  = (a_s < 0) && !uns;
  assign sb  = (b_s < 0) && !uns;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    dzo_d     = 1'b0;
    dz_flag_d = dz_flag_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;

    case (state_q)
      S_IDLE: begin
        // done_q high means this is the result cycle; a start here is dropped.
        if (start && !done_q) begin
          is_div_d = op[0];
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          cnt_d    = 5'd0;
          if (op[0]) begin
            acc_d  = {32'd0, cneg32(a, sa)};
            opnd_d = cneg32(b, sb);
          end else begin
            acc_d  = {32'd0, cneg32(b, sb)};
            opnd_d = cneg32(a, sa);
          end
          if (op[0] && (b == 32'd0)) begin
            dz_flag_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            dz_flag_d = 1'b0;
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        done_d = 1'b1;
        dzo_d  = dz_flag_q;
        if (!dz_flag_q) begin
          if (is_div_q) begin
            lo_d = cneg32(acc_q[31:0], neg_q);
            hi_d = cneg32(acc_q[63:32], rneg_q);
          end else begin
            {hi_d, lo_d} = cneg64(acc_q, neg_q);
          end
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
      dz_flag_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
      dz_flag_q <= dz_flag_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_q    <= neg_d;
    rneg_q   <= rneg_d;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
